// File: rtl/emac_mdio_pkg.sv
`default_nettype none
//==============================================================================
// emac_mdio_pkg : register map, sequencer states and command layout
// Rev 1.0
//==============================================================================
package emac_mdio_pkg;

   localparam logic [3:0] REG_MDIOSEL  = 4'd0;
   localparam logic [3:0] REG_CMD      = 4'd1;
   localparam logic [3:0] REG_OPDATA   = 4'd2;
   localparam logic [3:0] REG_RESULT   = 4'd3;
   localparam logic [3:0] REG_STATUS   = 4'd4;
   localparam logic [3:0] REG_TIMEOUT  = 4'd5;
   localparam logic [3:0] REG_COUNTERS = 4'd6;
   localparam logic [3:0] REG_VERSION  = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CONFWR = 3'd2,
      ST_CONFRD0 = 3'd3,
      ST_CONFRD1 = 3'd4,
      ST_MREQ   = 3'd5,
      ST_MWAIT  = 3'd6
   } state_t;

   localparam int STS_BUSY    = 0;
   localparam int STS_FULL    = 1;
   localparam int STS_EMPTY   = 2;
   localparam int STS_OVF     = 8;
   localparam int STS_TMO     = 9;
   localparam int STS_BADCH   = 10;
   localparam int STS_LCH_LSB = 20;

   localparam int CMD_CHAN_LSB = 20;
   localparam int CMD_TYPE_LSB = 16;
   localparam int CMD_ADDR_LSB = 0;

   localparam logic [31:0] RESULT_TIMEOUT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [3:0]  chan;
      logic [2:0]  op_type;
      logic [15:0] addr;
      logic [31:0] data;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Config ops address the EMAC register space; MDIO ops carry {phyad, regad}.
   function automatic logic [9:0] host_addr(input cmd_t c);
      return c.op_type[0] ? {1'b1, c.addr[8:0]} : {c.addr[12:8], c.addr[4:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_cmd_fifo.sv
`default_nettype none
//==============================================================================
// mdio_cmd_fifo : synchronous command queue, fall-through head, drop on full
// Rev 1.0
//==============================================================================
module mdio_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 55
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == c_DEPTH);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/emac_mdio_wb_mc.sv
`default_nettype none
//==============================================================================
// emac_mdio_wb_mc : Wishbone command-queue bridge to NUM_CH EMAC/PHY host ports
// Rev 1.0
//==============================================================================
module emac_mdio_wb_mc
   import emac_mdio_pkg::*;
#(
   parameter int          NUM_CH     = 4,
   parameter int          CMDQ_DEPTH = 8,
   parameter int          TIMEOUT_W  = 24,
   parameter logic [31:0] VERSION    = 32'h0002_0000
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_n_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic                   wb_we_i,
   input  logic [3:0]             wb_sel_i,
   input  logic [31:0]            wb_adr_i,
   input  logic [31:0]            wb_dat_i,
   output logic [31:0]            wb_dat_o,
   output logic                   wb_ack_o,
   output logic                   wb_err_o,
   output logic                   hostclk,
   output logic [1:0]             hostopcode,
   output logic [9:0]             hostaddr,
   output logic [31:0]            hostwrdata,
   output logic [NUM_CH-1:0]      hostreq,
   output logic [NUM_CH-1:0]      hostmiimsel,
   input  logic [32*NUM_CH-1:0]   hostrddata,
   input  logic [NUM_CH-1:0]      hostmiimrdy,
   output logic [NUM_CH-1:0]      mdio_sel
);

   localparam int         c_AW     = $clog2(CMDQ_DEPTH);
   localparam logic [4:0] c_NUM_CH = 5'(NUM_CH);

   logic                  r_ack;
   logic [NUM_CH-1:0]     r_mdio_sel;
   logic [31:0]           r_opdata;
   logic [TIMEOUT_W-1:0]  r_tlimit;
   logic [TIMEOUT_W-1:0]  r_tcnt;
   state_t                r_state;
   cmd_t                  r_cmd;
   logic [31:0]           r_result;
   logic                  r_ovf;
   logic                  r_tmo;
   logic                  r_bad;
   logic [3:0]            r_last_ch;
   logic [15:0]           r_done_cnt;
   logic [15:0]           r_tmo_cnt;

   logic                  w_acc;
   logic                  w_wr;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [c_AW:0]         w_count;
   cmd_t                  w_head;
   cmd_t                  w_new_cmd;
   logic [NUM_CH-1:0]     w_sel;
   logic [31:0]           w_rd;
   logic                  w_rdy;
   logic                  w_chan_ok;
   logic                  w_tmo;
   logic                  w_done;
   logic                  w_set_bad;
   logic [2:0]            w_clr;
   logic                  w_conf_st;
   logic [31:0]           w_dat;
   logic                  w_unused;

   assign w_unused = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0]};

   assign hostclk  = wb_clk_i;
   assign wb_err_o = 1'b0;
   assign wb_ack_o = r_ack;
   assign wb_dat_o = w_dat;
   assign mdio_sel = r_mdio_sel;

   assign w_acc  = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr   = w_acc & wb_we_i;
   assign w_push = w_wr && (wb_adr_i[5:2] == REG_CMD);
   assign w_pop  = (r_state == ST_IDLE) && !w_empty;
   assign w_clr  = (w_wr && (wb_adr_i[5:2] == REG_STATUS)) ? wb_dat_i[STS_BADCH:STS_OVF] : 3'b000;

   assign w_new_cmd = {wb_dat_i[CMD_CHAN_LSB +: 4], wb_dat_i[CMD_TYPE_LSB +: 3],
                       wb_dat_i[CMD_ADDR_LSB +: 16], r_opdata};

   mdio_cmd_fifo #(
      .DEPTH (CMDQ_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_n_i),
      .i_push  (w_push),
      .i_data  (w_new_cmd),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Per-channel decode of the active command's target port.
   always_comb begin
      w_sel = '0;
      w_rd  = '0;
      w_rdy = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_cmd.chan == c[3:0]) begin
            w_sel[c] = 1'b1;
            w_rd     = hostrddata[32*c +: 32];
            w_rdy    = hostmiimrdy[c];
         end
      end
   end

   assign w_chan_ok = ({1'b0, r_cmd.chan} < c_NUM_CH);
   assign w_conf_st = (r_state == ST_CONFWR) || (r_state == ST_CONFRD0) || (r_state == ST_CONFRD1);
   assign w_tmo     = (r_state != ST_IDLE) && (r_tcnt == r_tlimit);
   assign w_done    = !w_tmo && ((r_state == ST_CONFWR) || (r_state == ST_CONFRD1) ||
                                 ((r_state == ST_MWAIT) && w_rdy));
   assign w_set_bad = !w_tmo && (r_state == ST_LOAD) && !w_chan_ok;

   assign hostopcode  = r_cmd.op_type[2:1];
   assign hostaddr    = host_addr(r_cmd);
   assign hostwrdata  = r_cmd.data;
   assign hostreq     = (r_state == ST_MREQ) ? w_sel : '0;
   assign hostmiimsel = w_conf_st ? ~w_sel : '1;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         r_ack      <= 1'b0;
         r_mdio_sel <= '0;
         r_opdata   <= '0;
         r_tlimit   <= '1;
      end else begin
         r_ack <= w_acc;
         if (w_wr) begin
            case (wb_adr_i[5:2])
               REG_MDIOSEL: r_mdio_sel <= wb_dat_i[NUM_CH-1:0];
               REG_OPDATA:  r_opdata   <= wb_dat_i;
               REG_TIMEOUT: r_tlimit   <= wb_dat_i[TIMEOUT_W-1:0];
               default:     ;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         r_state    <= ST_IDLE;
         r_cmd      <= '0;
         r_tcnt     <= '0;
         r_result   <= '0;
         r_ovf      <= 1'b0;
         r_tmo      <= 1'b0;
         r_bad      <= 1'b0;
         r_last_ch  <= '0;
         r_done_cnt <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         r_tcnt <= (r_state == ST_IDLE) ? '0 : r_tcnt + 1'b1;
         r_ovf  <= (r_ovf & ~w_clr[0]) | (w_push & w_full);
         r_tmo  <= (r_tmo & ~w_clr[1]) | w_tmo;
         r_bad  <= (r_bad & ~w_clr[2]) | w_set_bad;
         if (w_done) begin
            r_done_cnt <= r_done_cnt + 16'd1;
            r_last_ch  <= r_cmd.chan;
         end
         // A timeout overrides whatever the state would have done this cycle.
         if (w_tmo) begin
            r_state   <= ST_IDLE;
            r_result  <= RESULT_TIMEOUT;
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_empty) begin
                     r_cmd   <= w_head;
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (!w_chan_ok)             r_state <= ST_IDLE;
                  else if (!r_cmd.op_type[0]) r_state <= ST_MREQ;
                  else if (r_cmd.op_type[2])  r_state <= ST_CONFRD0;
                  else                        r_state <= ST_CONFWR;
               end
               ST_CONFWR:  r_state <= ST_IDLE;
               ST_CONFRD0: r_state <= ST_CONFRD1;
               ST_CONFRD1: begin
                  r_result <= w_rd;
                  r_state  <= ST_IDLE;
               end
               ST_MREQ:    r_state <= ST_MWAIT;
               ST_MWAIT: begin
                  if (w_rdy) begin
                     r_result <= w_rd;
                     r_state  <= ST_IDLE;
                  end
               end
               default:    r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      w_dat = '0;
      case (wb_adr_i[5:2])
         REG_MDIOSEL:  w_dat[NUM_CH-1:0] = r_mdio_sel;
         REG_CMD:      w_dat[c_AW:0] = w_count;
         REG_OPDATA:   w_dat = r_opdata;
         REG_RESULT:   w_dat = r_result;
         REG_STATUS: begin
            w_dat[STS_BUSY]            = (r_state != ST_IDLE) || (w_count != '0);
            w_dat[STS_FULL]            = w_full;
            w_dat[STS_EMPTY]           = w_empty;
            w_dat[STS_OVF]             = r_ovf;
            w_dat[STS_TMO]             = r_tmo;
            w_dat[STS_BADCH]           = r_bad;
            w_dat[STS_LCH_LSB +: 4]    = r_last_ch;
         end
         REG_TIMEOUT:  w_dat[TIMEOUT_W-1:0] = r_tlimit;
         REG_COUNTERS: w_dat = {r_tmo_cnt, r_done_cnt};
         REG_VERSION:  w_dat = VERSION;
         default:      w_dat = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_emac_mdio_wb_mc.sv
`default_nettype none
//==============================================================================
// tb_emac_mdio_wb_mc : directed scoreboard bench for the multi-channel bridge
// Rev 1.0
//==============================================================================
module tb_emac_mdio_wb_mc;

   localparam int NUM_CH = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]            wb_sel_i;
   logic [31:0]           wb_adr_i, wb_dat_i;
   logic [31:0]           wb_dat_o;
   logic                  wb_ack_o, wb_err_o, hostclk;
   logic [1:0]            hostopcode;
   logic [9:0]            hostaddr;
   logic [31:0]           hostwrdata;
   logic [NUM_CH-1:0]     hostreq, hostmiimsel, mdio_sel;
   logic [32*NUM_CH-1:0]  hostrddata;
   logic [NUM_CH-1:0]     resp_rdy = '0;
   logic [NUM_CH-1:0]     man_rdy  = '0;
   logic [NUM_CH-1:0]     hostmiimrdy;

   assign hostmiimrdy = resp_rdy | man_rdy;

   always #5 clk = ~clk;

   emac_mdio_wb_mc #(
      .NUM_CH (NUM_CH), .CMDQ_DEPTH (8), .TIMEOUT_W (24), .VERSION (32'h0002_0000)
   ) dut (
      .wb_clk_i (clk), .wb_rst_n_i (rst_n),
      .wb_cyc_i (wb_cyc_i), .wb_stb_i (wb_stb_i), .wb_we_i (wb_we_i),
      .wb_sel_i (wb_sel_i), .wb_adr_i (wb_adr_i), .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o), .wb_ack_o (wb_ack_o), .wb_err_o (wb_err_o),
      .hostclk (hostclk), .hostopcode (hostopcode), .hostaddr (hostaddr),
      .hostwrdata (hostwrdata), .hostreq (hostreq), .hostmiimsel (hostmiimsel),
      .hostrddata (hostrddata), .hostmiimrdy (hostmiimrdy), .mdio_sel (mdio_sel)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct { string name; logic [31:0] exp; } rd_exp_t;
   typedef struct { string name; logic [63:0] exp; } host_exp_t;
   rd_exp_t   rd_q[$];
   host_exp_t req_q[$];
   host_exp_t conf_q[$];

   function automatic logic [63:0] req_exp(input logic [3:0] req, input logic [9:0] a,
                                           input logic [1:0] op, input logic [31:0] d);
      return {16'b0, req, a, op, d};
   endfunction

   function automatic logic [63:0] conf_exp(input logic [3:0] msel, input logic [9:0] a,
                                            input logic [1:0] op, input logic [31:0] d);
      return {12'b0, msel, a, op, d, 4'b0000};
   endfunction

   // Read-data monitor: every read ack is matched against the oldest expectation.
   always @(negedge clk) begin : mon_rd
      rd_exp_t e;
      if (rst_n && wb_ack_o && !wb_we_i) begin
         if (rd_q.size() == 0) begin
            n_total++;
            $display("FAIL rd_unexpected: got read data %h with nothing expected", wb_dat_o);
         end else begin
            e = rd_q.pop_front();
            chk(e.name, 64'(wb_dat_o), 64'(e.exp));
         end
      end
   end

   // MDIO request monitor: each hostreq cycle consumes one expected request.
   always @(negedge clk) begin : mon_req
      host_exp_t e;
      if (hostreq != '0) begin
         if (req_q.size() == 0) begin
            n_total++;
            $display("FAIL req_unexpected: got hostreq %h addr %h", hostreq, hostaddr);
         end else begin
            e = req_q.pop_front();
            chk(e.name, {16'b0, hostreq, hostaddr, hostopcode, hostwrdata}, e.exp);
         end
      end
   end

   // Config monitor: each cycle with a channel deselected from MIIM consumes one entry.
   always @(negedge clk) begin : mon_conf
      host_exp_t e;
      if (hostmiimsel != '1) begin
         if (conf_q.size() == 0) begin
            n_total++;
            $display("FAIL conf_unexpected: got hostmiimsel %h addr %h", hostmiimsel, hostaddr);
         end else begin
            e = conf_q.pop_front();
            chk(e.name, {12'b0, hostmiimsel, hostaddr, hostopcode, hostwrdata, hostreq}, e.exp);
         end
      end
   end

   // PHY responder: raises rdy on the requested channel 5 cycles after hostreq.
   bit rdy_en   = 1'b0;
   int resp_cnt = 0;
   int resp_ch  = 0;
   always @(posedge clk) begin
      #1;
      resp_rdy = '0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) resp_rdy[resp_ch] = 1'b1;
      end
      if (rdy_en && hostreq != '0) begin
         for (int c = 0; c < NUM_CH; c++) if (hostreq[c]) resp_ch = c;
         resp_cnt = 5;
      end
   end

   task automatic wb_cycle(input logic [3:0] idx, input logic [31:0] d, input logic w);
      int n;
      @(posedge clk); #1;
      wb_adr_i = {26'b0, idx, 2'b00};
      wb_dat_i = d;
      wb_we_i  = w;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack_o && n < 20);
      if (!wb_ack_o) begin
         n_total++;
         $display("FAIL wb_ack_timeout: got no ack for index %0d required ack within 20 cycles", idx);
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
   endtask

   task automatic wr(input logic [3:0] idx, input logic [31:0] d);
      wb_cycle(idx, d, 1'b1);
   endtask

   task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string name);
      rd_q.push_back('{name, exp});
      wb_cycle(idx, 32'h0, 1'b0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at 200us");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      wb_sel_i   = 4'hF;
      wb_adr_i   = '0;
      wb_dat_i   = '0;
      hostrddata = {32'h3333_3333, 32'h0000_BEEF, 32'hC0FF_EE01, 32'h0000_0A0A};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset values
      chk("rst_hostmiimsel", 64'(hostmiimsel), 64'(4'hF));
      chk("rst_hostreq", 64'(hostreq), 64'(4'h0));
      chk("rst_mdio_sel", 64'(mdio_sel), 64'(4'h0));
      rd(4'd4, 32'h0000_0004, "rst_status");
      rd(4'd5, 32'h00FF_FFFF, "rst_timeout");
      rd(4'd7, 32'h0002_0000, "rst_version");
      rd(4'd3, 32'h0, "rst_result");
      rd(4'd6, 32'h0, "rst_counters");
      rd(4'd1, 32'h0, "rst_cmd_count");
      rd(4'd8, 32'h0, "unmapped_8");
      wr(4'd0, 32'h0000_005A);
      rd(4'd0, 32'h0000_000A, "mdiosel_rw");
      chk("mdio_sel_port", 64'(mdio_sel), 64'(4'hA));

      // MDIO read on channel 2, PHY answers after 5 cycles
      rdy_en = 1'b1;
      wr(4'd2, 32'h0000_1234);
      req_q.push_back('{"mdio_ch2_req", req_exp(4'b0100, 10'h025, 2'b00, 32'h0000_1234)});
      wr(4'd1, 32'h0020_0105);
      repeat (20) @(posedge clk);
      rd(4'd3, 32'h0000_BEEF, "mdio_ch2_result");
      rd(4'd6, 32'h0000_0001, "mdio_ch2_counters");
      rd(4'd4, 32'h0020_0004, "mdio_ch2_status");

      // Config read on channel 1: CONFRD0 and CONFRD1 drive the host port
      conf_q.push_back('{"confrd_ch1_c0", conf_exp(4'b1101, 10'h233, 2'b10, 32'h0000_1234)});
      conf_q.push_back('{"confrd_ch1_c1", conf_exp(4'b1101, 10'h233, 2'b10, 32'h0000_1234)});
      wr(4'd1, 32'h0015_0033);
      repeat (10) @(posedge clk);
      rd(4'd3, 32'hC0FF_EE01, "confrd_result");
      rd(4'd4, 32'h0010_0004, "confrd_status");

      // Config write on channel 3, single host cycle
      wr(4'd2, 32'h0000_CAFE);
      conf_q.push_back('{"confwr_ch3", conf_exp(4'b0111, 10'h3FF, 2'b00, 32'h0000_CAFE)});
      wr(4'd1, 32'h0031_01FF);
      repeat (10) @(posedge clk);
      rd(4'd6, 32'h0000_0003, "confwr_counters");
      rd(4'd3, 32'hC0FF_EE01, "confwr_result_kept");
      rd(4'd4, 32'h0030_0004, "confwr_status");

      // Timeout on channel 0 with no PHY response
      rdy_en = 1'b0;
      wr(4'd5, 32'd16);
      rd(4'd5, 32'h0000_0010, "timeout_rw");
      req_q.push_back('{"tmo_ch0_req", req_exp(4'b0001, 10'h000, 2'b00, 32'h0000_CAFE)});
      wr(4'd1, 32'h0000_0000);
      repeat (30) @(posedge clk);
      rd(4'd4, 32'h0030_0204, "tmo_status");
      rd(4'd3, 32'hFFFF_FFFF, "tmo_result");
      rd(4'd6, 32'h0001_0003, "tmo_counters");
      wr(4'd4, 32'h0000_0200);
      rd(4'd4, 32'h0030_0004, "tmo_w1c");

      // Queue fill: 9 accepted (one popped at once), the 10th overflows
      wr(4'd5, 32'd40);
      for (int i = 0; i < 10; i++) begin
         if (i < 9) req_q.push_back('{"ovf_req", req_exp(4'b0001, 10'(i), 2'b00, 32'h0000_CAFE)});
         wr(4'd1, 32'(i));
      end
      rd(4'd4, 32'h0030_0103, "ovf_status_full");
      rd(4'd1, 32'h0000_0008, "ovf_count");
      repeat (450) @(posedge clk);
      rd(4'd6, 32'h000A_0003, "ovf_counters");
      rd(4'd4, 32'h0030_0304, "ovf_status_drained");
      wr(4'd4, 32'h0000_0300);
      rd(4'd4, 32'h0030_0004, "ovf_w1c");

      // Channel 7 does not exist: flagged, no host activity
      wr(4'd1, 32'h0070_0000);
      repeat (10) @(posedge clk);
      rd(4'd4, 32'h0030_0404, "badch_status");
      rd(4'd6, 32'h000A_0003, "badch_counters");
      wr(4'd4, 32'h0000_0400);
      rd(4'd4, 32'h0030_0004, "badch_w1c");

      // Reset while waiting on the PHY with 3 commands queued
      req_q.push_back('{"rst_mwait_req", req_exp(4'b0100, 10'h000, 2'b00, 32'h0000_CAFE)});
      for (int i = 0; i < 4; i++) wr(4'd1, 32'h0020_0000);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rst_mid_hostreq", 64'(hostreq), 64'(4'h0));
      chk("rst_mid_hostmiimsel", 64'(hostmiimsel), 64'(4'hF));
      man_rdy[2] = 1'b1;
      @(posedge clk); #1 man_rdy = '0;
      repeat (10) @(posedge clk);
      rd(4'd4, 32'h0000_0004, "rst_mid_status");
      rd(4'd6, 32'h0, "rst_mid_counters");
      rd(4'd3, 32'h0, "rst_mid_result");
      rd(4'd5, 32'h00FF_FFFF, "rst_mid_timeout");
      rd(4'd2, 32'h0, "rst_mid_opdata");
      rd(4'd0, 32'h0, "rst_mid_mdiosel");

      repeat (3) @(posedge clk);
      chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
      chk("req_q_drained", 64'(req_q.size()), 64'd0);
      chk("conf_q_drained", 64'(conf_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
